multicycle_controller: RTL
==========================

# multicycle_controller

- Moore-style control FSM for the team's multicycle RV32I-subset datapath.
- Sequences fetch, decode, execute, memory and writeback for each instruction.
- Drives every datapath strobe and mux select, using the latched instruction (IR) and the ALU zero flag as inputs.
- Halts on any unsupported encoding.

## Interface
Parameters:
- none

Ports:
- clk  in  1  clock; reset reset, asynchronous, active-high; clock clk.
- reset  in  1  asynchronous active-high reset.
- instr  in  32  current IR contents from the datapath.
- zero  in  1  combinational (alu_result == 0) from the datapath.
- pc_write  out  1  PC loads alu_out.
- ir_write  out  1  IR loads mem[pc].
- mem_write  out  1  mem[alu_out] gets rs2 data.
- reg_write  out  1  rd gets result.
- instruction_or_data  out  1  address select: 0 = pc, 1 = result.
- result_src  out  2  result select: 00 = alu_out, 01 = read data, 10 = alu_result.
- alu_src_a  out  2  ALU A select: 00 = pc, 01 = rs1.
- alu_src_b  out  2  ALU B select: 00 = rs2, 01 = 4, 10 = imm, 11 = 0.
- alu_control  out  3  ALU op: 000 add, 001 sub, 010 and, 011 or, 101 slt.
- halted  out  1  sticky illegal-instruction flag.
- state_out  out  4  current state, for debug.
- instret  out  32  retired-instruction count; present only with MC_CTRL_PERF_EN.

## Operation
State encodings:
- FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXEC_R=6, EXEC_I=7, ALUWB=8, BEQ=9, BTARGET=10, BTAKE=11, HALT=15.

Default outputs:
- All strobes 0, instruction_or_data=0, result_src=00, alu_src_a=00, alu_src_b=01, alu_control=000, halted=0.
- States override only the fields listed below.

Per-state outputs and transitions:
- FETCH: ir_write=1, a=pc, b=4, add → DECODE.
- DECODE: pc_write=1 (PC ← pc+4 captured in FETCH); a=rs1, b=imm, add. Next state by opcode:
  - 0000011 with funct3 010 (lw) → MEMADR.
  - 0100011 with funct3 010 (sw) → MEMADR.
  - 0110011 → EXEC_R.
  - 0010011 → EXEC_I.
  - 1100011 with funct3 000 (beq) → BEQ.
  - Anything else → HALT.
- MEMADR: a=rs1, b=imm, add → MEMREAD if opcode is lw, otherwise MEMWRITE.
- MEMREAD: instruction_or_data=1, result_src=00 → MEMWB.
- MEMWB: result_src=01, reg_write=1 → FETCH.
- MEMWRITE: mem_write=1 → FETCH.
- EXEC_R: a=rs1, b=rs2, op from funct3/funct7[5]:
  - 000/0 → add; 000/1 → sub; 111 → and; 110 → or; 010 → slt.
  - Any other funct3, or funct7 other than 0000000/0100000 → HALT.
  - Otherwise → ALUWB.
- EXEC_I: a=rs1, b=imm, same funct3 map, always add-type for 000 → ALUWB; unsupported funct3 → HALT.
- ALUWB: result_src=00, reg_write=1 → FETCH.
- BEQ: a=rs1, b=rs2, sub. zero=1 → BTARGET; zero=0 → FETCH.
- BTARGET: a=pc, b=imm, add. Branch offsets are relative to the incremented PC; the datapath immediate generator owns offset formation. → BTAKE.
- BTAKE: pc_write=1 → FETCH.
- HALT: all strobes 0, halted=1. Stays in HALT until reset.

## Timing
- State register updates on posedge clk. Outputs are combinational from state and instr only; zero affects only the next state.
- Reset: state=FETCH, asynchronously. All write strobes are forced to 0 while reset is high, even in FETCH. Selects show FETCH values. halted=0, instret=0.
- Cycles per instruction:
  - lw: 5 (F, D, MA, MR, WB).
  - sw: 4.
  - R-type and I-type ALU: 4.
  - beq not taken: 3.
  - beq taken: 5.
  - Illegal: 2 cycles, then HALT.
- Reset deasserted mid-instruction restarts at FETCH. No partial strobe is issued in the first cycle after release unless the state is FETCH.
- instr is sampled only in DECODE and later states. IR contents during FETCH are don't-care.

## Configuration
- MC_CTRL_PERF_EN defined:
  - instret port present.
  - Increments by 1 (wrapping at 2^32) on the last cycle of each retired instruction: MEMWB, MEMWRITE, ALUWB, BTAKE, or BEQ with zero=0.
  - Never increments in HALT.
  - Reset to 0.
- Undefined: no counter and no instret port. All other behaviour is identical.

## Test plan
- Reset then release, with IR = lw x1,8(x2) (0x00812083):
  - States 0,1,2,3,4,0.
  - MEMREAD has instruction_or_data=1.
  - MEMWB has result_src=01 and reg_write=1.
  - instret=1.
- sw x3,4(x2) (0x00312223):
  - States 0,1,2,5.
  - mem_write=1 for exactly one cycle.
  - reg_write never asserts.
- R-type sweep:
  - add (0x003100B3) → alu_control=000.
  - sub (0x403100B3) → 001.
  - and (0x003170B3) → 010.
  - or (0x003160B3) → 011.
  - slt (0x003120B3) → 101.
  - Each takes 4 cycles, with reg_write in ALUWB.
- beq (0x00208463):
  - zero=0 → 3 cycles, pc_write only in DECODE.
  - zero=1 → 5 cycles, pc_write in DECODE and BTAKE.
- Illegal opcode 0x0000007F → HALT after DECODE, halted=1, all strobes 0 for 20 cycles. A reset pulse returns to FETCH with halted=0.
- Asynchronous reset asserted during MEMWRITE:
  - state_out goes to 0 immediately.
  - mem_write drops within the same cycle.
  - instret is unchanged by the aborted instruction, then reads 0.

Source files
------------

// File: rtl/multicycle_controller.sv
// Moore control FSM for the multicycle RV32I-subset datapath (lw, sw, R/I ALU, beq).
// Outputs are combinational from state and IR; write strobes are held low during reset.
// Optional retired-instruction counter on port instret when MC_CTRL_PERF_EN is defined.
module multicycle_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        zero,
    output logic        pc_write,
    output logic        ir_write,
    output logic        mem_write,
    output logic        reg_write,
    output logic        instruction_or_data,
    output logic [1:0]  result_src,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [2:0]  alu_control,
    output logic        halted,
    output logic [3:0]  state_out
`ifdef MC_CTRL_PERF_EN
    ,
    output logic [31:0] instret
`endif
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXEC_R   = 4'd6,
        S_EXEC_I   = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_BTARGET  = 4'd10,
        S_BTAKE    = 4'd11,
        S_HALT     = 4'd15
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    state_t state;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       unused_instr_bits;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    // Register indices and immediates belong to the datapath, not to control.
    assign unused_instr_bits = ^{instr[24:15], instr[11:7]};

    // funct3 -> ALU op; funct7[5] selects sub only for R-type add/sub.
    logic [2:0] alu_op_dec;
    logic       f3_legal;
    logic       f7_legal;
    logic       exec_r_legal;
    logic       exec_i_legal;

    // Shared ALU-op decode for R-type and I-type arithmetic.
    always_comb begin
        alu_op_dec = ALU_ADD;
        f3_legal   = 1'b1;
        case (funct3)
            3'b000:  alu_op_dec = (state == S_EXEC_R && funct7[5]) ? ALU_SUB : ALU_ADD;
            3'b111:  alu_op_dec = ALU_AND;
            3'b110:  alu_op_dec = ALU_OR;
            3'b010:  alu_op_dec = ALU_SLT;
            default: f3_legal   = 1'b0;
        endcase
    end

    assign f7_legal     = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
    assign exec_r_legal = f3_legal && f7_legal;
    assign exec_i_legal = f3_legal;

    // State register; zero only matters for the BEQ decision.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            case (state)
                S_FETCH:  state <= S_DECODE;
                S_DECODE: begin
                    if ((opcode == OP_LOAD || opcode == OP_STORE) && funct3 == 3'b010)
                        state <= S_MEMADR;
                    else if (opcode == OP_REG)
                        state <= S_EXEC_R;
                    else if (opcode == OP_IMM)
                        state <= S_EXEC_I;
                    else if (opcode == OP_BRANCH && funct3 == 3'b000)
                        state <= S_BEQ;
                    else
                        state <= S_HALT;
                end
                S_MEMADR:   state <= (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
                S_MEMREAD:  state <= S_MEMWB;
                S_MEMWB:    state <= S_FETCH;
                S_MEMWRITE: state <= S_FETCH;
                S_EXEC_R:   state <= exec_r_legal ? S_ALUWB : S_HALT;
                S_EXEC_I:   state <= exec_i_legal ? S_ALUWB : S_HALT;
                S_ALUWB:    state <= S_FETCH;
                S_BEQ:      state <= zero ? S_BTARGET : S_FETCH;
                S_BTARGET:  state <= S_BTAKE;
                S_BTAKE:    state <= S_FETCH;
                S_HALT:     state <= S_HALT;
                default:    state <= S_HALT;
            endcase
        end
    end

    // Per-state datapath controls; strobes are gated off while reset is high.
    always_comb begin
        pc_write            = 1'b0;
        ir_write            = 1'b0;
        mem_write           = 1'b0;
        reg_write           = 1'b0;
        instruction_or_data = 1'b0;
        result_src          = 2'b00;
        alu_src_a           = 2'b00;
        alu_src_b           = 2'b01;
        alu_control         = ALU_ADD;
        halted              = 1'b0;
        case (state)
            S_FETCH: begin
                ir_write  = 1'b1;
            end
            S_DECODE: begin
                pc_write  = 1'b1;
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
            end
            S_MEMADR: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
            end
            S_MEMREAD: begin
                instruction_or_data = 1'b1;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                mem_write = 1'b1;
            end
            S_EXEC_R: begin
                alu_src_a   = 2'b01;
                alu_src_b   = 2'b00;
                alu_control = alu_op_dec;
            end
            S_EXEC_I: begin
                alu_src_a   = 2'b01;
                alu_src_b   = 2'b10;
                alu_control = alu_op_dec;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
            end
            S_BEQ: begin
                alu_src_a   = 2'b01;
                alu_src_b   = 2'b00;
                alu_control = ALU_SUB;
            end
            S_BTARGET: begin
                alu_src_b = 2'b10;
            end
            S_BTAKE: begin
                pc_write = 1'b1;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                halted = 1'b1;
            end
        endcase
        if (reset) begin
            pc_write  = 1'b0;
            ir_write  = 1'b0;
            mem_write = 1'b0;
            reg_write = 1'b0;
        end
    end

    assign state_out = state;

`ifdef MC_CTRL_PERF_EN
    logic retire;
    assign retire = (state == S_MEMWB) || (state == S_MEMWRITE) || (state == S_ALUWB) ||
                    (state == S_BTAKE) || (state == S_BEQ && !zero);

    // Count instructions on their final cycle; wraps naturally at 2^32.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            instret <= 32'd0;
        else if (retire)
            instret <= instret + 32'd1;
    end
`endif

endmodule
